// File: rtl/gyro_fir_filter.sv
// gyro_fir_filter: time-multiplexed multi-channel FIR with bypass and runtime coefficient writes
// Ports: Clk/Reset_n - clock, asynchronous active-low reset
//        SampleValid/SampleReady/SampleData - sample handshake, channel 0 in LSBs
//        Bypass - forward the accepted sample unfiltered
//        CoefWe/CoefAddr/CoefData - write one tap (shared by all channels) while idle
//        OutValid/OutData - one-cycle result pulse, data held between pulses
//        CoefDropped - sticky flag for rejected coefficient writes
module gyro_fir_filter #(
  parameter int CHANNELS = 3,
  parameter int TAPS = 10,
  parameter int DATA_W = 10,
  parameter int COEF_W = 16,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {TAPS{COEF_W'(1 << (COEF_W - 2))}}
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic SampleValid,
  output logic SampleReady,
  input  logic [CHANNELS*DATA_W-1:0] SampleData,
  input  logic Bypass,
  input  logic CoefWe,
  input  logic [$clog2(TAPS)-1:0] CoefAddr,
  input  logic [COEF_W-1:0] CoefData,
  output logic OutValid,
  output logic [CHANNELS*DATA_W-1:0] OutData,
  output logic CoefDropped
);
  localparam int TW = $clog2(TAPS);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + TW;
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (COEF_W - 2);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
  typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;
  state_t state;
  logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, accSum, rounded;
  logic [DATA_W-1:0] satVal;
  logic [CHANNELS*DATA_W-1:0] res;
  logic [TW-1:0] tapIdx;
  logic [CW-1:0] chIdx;
  logic accept, coefOk;
  assign SampleReady = state == IDLE;
  always_comb begin
    accept = SampleValid && state == IDLE;
    coefOk = state == IDLE && !SampleValid && int'(CoefAddr) < TAPS;
    prod = PW'(hist[chIdx][tapIdx]) * PW'(coef[tapIdx]);
    // tap 0 starts a fresh channel sum instead of adding to the previous channel's
    accSum = tapIdx == '0 ? AW'(prod) : acc + AW'(prod);
    rounded = (accSum + HALF) >>> (COEF_W - 1);
    satVal = rounded > MAXV ? MAXV[DATA_W-1:0] : rounded < MINV ? MINV[DATA_W-1:0] : rounded[DATA_W-1:0];
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      acc <= '0;
      res <= '0;
      tapIdx <= '0;
      chIdx <= '0;
      OutValid <= 1'b0;
      OutData <= '0;
      CoefDropped <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      for (int t = 0; t < TAPS; t++) coef[t] <= COEF_INIT[t*COEF_W +: COEF_W];
    end else begin
      OutValid <= 1'b0;
      if (CoefWe) begin
        if (coefOk) coef[CoefAddr] <= CoefData;
        else CoefDropped <= 1'b1;
      end
      case (state)
        IDLE: if (accept) begin
          // res doubles as the sample stage: bypass forwards it, filtering shifts it into history
          res <= SampleData;
          state <= Bypass ? OUT : SHIFT;
        end
        SHIFT: begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int t = TAPS - 1; t > 0; t--) hist[c][t] <= hist[c][t-1];
            hist[c][0] <= res[c*DATA_W +: DATA_W];
          end
          tapIdx <= '0;
          chIdx <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= accSum;
          tapIdx <= tapIdx == LAST_TAP ? '0 : tapIdx + 1'b1;
          if (tapIdx == LAST_TAP) begin
            res[chIdx*DATA_W +: DATA_W] <= satVal;
            chIdx <= chIdx + 1'b1;
            if (chIdx == LAST_CH) state <= OUT;
          end
        end
        OUT: begin
          OutValid <= 1'b1;
          OutData <= res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gyro_fir_filter.sv
// tb_gyro_fir_filter: self-checking bench for gyro_fir_filter
module tb_gyro_fir_filter;
  localparam int CH = 3;
  localparam int TAPS = 10;
  localparam int DW = 10;
  localparam int CWID = 16;
  localparam int NW = CH * DW;
  typedef struct {
    int setup;
    bit byp;
    logic [NW-1:0] din;
    logic [NW-1:0] exp;
  } vec_t;
  logic Clk = 0;
  logic Reset_n = 0;
  logic SampleValid = 0;
  logic Bypass = 0;
  logic CoefWe = 0;
  logic [NW-1:0] SampleData = '0;
  logic [3:0] CoefAddr = '0;
  logic [CWID-1:0] CoefData = '0;
  logic SampleReady, OutValid, CoefDropped;
  logic [NW-1:0] OutData;
  int checks = 0;
  int errors = 0;
  int waitCnt;
  int modelHist[CH][$];
  int modelCoef[TAPS];
  vec_t vecs[$];

  gyro_fir_filter dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .SampleValid(SampleValid),
    .SampleReady(SampleReady),
    .SampleData(SampleData),
    .Bypass(Bypass),
    .CoefWe(CoefWe),
    .CoefAddr(CoefAddr),
    .CoefData(CoefData),
    .OutValid(OutValid),
    .OutData(OutData),
    .CoefDropped(CoefDropped)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] pk(int a, int b, int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic int sx(logic [NW-1:0] d, int c);
    logic signed [DW-1:0] v;
    v = d[c*DW +: DW];
    return v;
  endfunction

  // reference: newest sample at the front of each channel's history queue
  function automatic void modelReset();
    for (int c = 0; c < CH; c++) begin
      modelHist[c].delete();
      repeat (TAPS) modelHist[c].push_back(0);
    end
    for (int t = 0; t < TAPS; t++) modelCoef[t] = 16384;
  endfunction

  function automatic logic [NW-1:0] modelApply(logic [NW-1:0] d, bit byp);
    logic [NW-1:0] r;
    longint s, y;
    if (byp) return d;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      modelHist[c].push_front(sx(d, c));
      void'(modelHist[c].pop_back());
      s = 0;
      for (int t = 0; t < TAPS; t++) s += longint'(modelHist[c][t]) * longint'(modelCoef[t]);
      y = (s + 16384) >>> 15;
      if (y > 511) y = 511;
      if (y < -512) y = -512;
      r[c*DW +: DW] = DW'(y);
    end
    return r;
  endfunction

  task automatic doReset();
    @(negedge Clk);
    Reset_n = 0;
    SampleValid = 0;
    CoefWe = 0;
    Bypass = 0;
    @(negedge Clk);
    Reset_n = 1;
    modelReset();
  endtask

  task automatic wrCoef(input int a, input int v);
    @(negedge Clk);
    CoefWe = 1;
    CoefAddr = 4'(a);
    CoefData = CWID'(v);
    @(negedge Clk);
    CoefWe = 0;
    if (a < TAPS) modelCoef[a] = v;
  endtask

  // weMode: 0 none, 1 coefficient write coincident with acceptance, 2 write during MAC
  task automatic run(input string nm, input logic [NW-1:0] d, input bit byp, input logic [NW-1:0] exp, input int weMode);
    int w = 0;
    int lat = 0;
    logic [NW-1:0] got;
    @(negedge Clk);
    while (!SampleReady && w < 60) begin
      @(negedge Clk);
      w++;
    end
    check({nm, " ready"}, SampleReady, 1);
    SampleValid = 1;
    SampleData = d;
    Bypass = byp;
    CoefWe = weMode == 1;
    CoefAddr = 4'd2;
    CoefData = '0;
    @(posedge Clk);
    #1;
    SampleValid = 0;
    Bypass = !byp;
    SampleData = NW'($urandom);
    CoefWe = 0;
    CoefAddr = 4'd0;
    while (!OutValid && lat < 60) begin
      @(posedge Clk);
      #1;
      lat++;
      CoefWe = weMode == 2 && lat == 10;
    end
    got = OutData;
    check({nm, " latency"}, lat, byp ? 1 : 32);
    check({nm, " data"}, got, exp);
    @(posedge Clk);
    #1;
    CoefWe = 0;
    check({nm, " pulse"}, OutValid, 0);
    check({nm, " hold"}, OutData, got);
  endtask

  initial begin
    // impulse on channel 0 with a bypass sample interleaved (history must not shift)
    vecs.push_back('{1, 0, pk(100, 0, 0), pk(50, 0, 0)});
    for (int i = 0; i < 4; i++) vecs.push_back('{0, 0, pk(0, 0, 0), pk(50, 0, 0)});
    vecs.push_back('{0, 1, pk(7, -7, 300), pk(7, -7, 300)});
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 0, pk(0, 0, 0), pk(50, 0, 0)});
    for (int i = 0; i < 2; i++) vecs.push_back('{0, 0, pk(0, 0, 0), pk(0, 0, 0)});
    // rounding: tap 0 = 0.5 only
    vecs.push_back('{2, 0, pk(1, -1, 3), pk(1, 0, 2)});
    vecs.push_back('{0, 0, pk(-1, 3, 1), pk(0, 2, 1)});
    vecs.push_back('{0, 0, pk(3, 1, -1), pk(2, 1, 0)});
    vecs.push_back('{0, 0, pk(-3, 5, -2), pk(-1, 3, -1)});
    // saturation: all taps 0x7FFF
    for (int i = 0; i < 3; i++) vecs.push_back('{i == 0 ? 3 : 0, 0, pk(511, -512, 0), pk(511, -512, 0)});
    vecs.push_back('{0, 0, pk(0, 0, 5), pk(511, -512, 5)});

    repeat (2) @(negedge Clk);
    check("rst ready", SampleReady, 1);
    check("rst outvalid", OutValid, 0);
    check("rst outdata", OutData, 0);
    check("rst dropped", CoefDropped, 0);
    Reset_n = 1;
    modelReset();

    foreach (vecs[i]) begin
      if (vecs[i].setup != 0) doReset();
      if (vecs[i].setup == 2) for (int t = 0; t < TAPS; t++) wrCoef(t, t == 0 ? 16384 : 0);
      if (vecs[i].setup == 3) for (int t = 0; t < TAPS; t++) wrCoef(t, 32767);
      run($sformatf("vec%0d", i), vecs[i].din, vecs[i].byp, vecs[i].exp, 0);
    end

    // SampleValid held high: acceptance spacing and output latency
    doReset();
    begin
      int accEdges[$];
      int outEdges[$];
      int k;
      k = 0;
      repeat (110) begin
        @(negedge Clk);
        SampleValid = 1;
        SampleData = NW'($urandom);
        if (SampleReady) accEdges.push_back(k + 1);
        if (OutValid) outEdges.push_back(k);
        @(posedge Clk);
        k++;
      end
      SampleValid = 0;
      check("hs accepts", accEdges.size(), 4);
      check("hs outputs", outEdges.size(), 3);
      for (int i = 1; i < accEdges.size(); i++) check("hs interval", accEdges[i] - accEdges[i-1], 33);
      for (int i = 0; i < outEdges.size(); i++) check("hs latency", outEdges[i] - accEdges[i], 32);
    end

    // coefficient write rules
    doReset();
    check("drop clear", CoefDropped, 0);
    wrCoef(1, 8192);
    check("good write no drop", CoefDropped, 0);
    run("coef accdrop", pk(100, 0, 0), 0, modelApply(pk(100, 0, 0), 0), 1);
    check("drop on accept", CoefDropped, 1);
    for (int i = 0; i < 3; i++) run("coef seq", pk(0, 0, 0), 0, modelApply(pk(0, 0, 0), 0), 0);
    doReset();
    run("coef macdrop", pk(100, -100, 0), 0, modelApply(pk(100, -100, 0), 0), 2);
    check("drop in mac", CoefDropped, 1);
    run("coef macdrop next", pk(100, 0, 0), 0, modelApply(pk(100, 0, 0), 0), 0);
    doReset();
    wrCoef(12, 0);
    check("drop addr", CoefDropped, 1);
    for (int i = 0; i < 3; i++) run("coef addr seq", pk(i == 0 ? 100 : 0, 0, 0), 0, modelApply(pk(i == 0 ? 100 : 0, 0, 0), 0), 0);
    check("drop sticky", CoefDropped, 1);
    doReset();
    check("drop reset", CoefDropped, 0);

    // reset in MAC cycle 15: no output, then a clean restart from COEF_INIT
    wrCoef(0, 0);
    @(negedge Clk);
    SampleValid = 1;
    SampleData = pk(100, 0, 0);
    Bypass = 0;
    @(posedge Clk);
    #1;
    SampleValid = 0;
    repeat (15) @(posedge Clk);
    #1;
    Reset_n = 0;
    #1;
    check("midrst outvalid", OutValid, 0);
    check("midrst outdata", OutData, 0);
    check("midrst ready", SampleReady, 1);
    repeat (3) begin
      @(posedge Clk);
      #1;
      check("midrst held", OutValid, 0);
    end
    @(negedge Clk);
    SampleValid = 1;
    SampleData = pk(100, 0, 0);
    Reset_n = 1;
    modelReset();
    @(posedge Clk);
    #1;
    SampleValid = 0;
    check("first edge accept", SampleReady, 0);
    waitCnt = 0;
    while (!OutValid && waitCnt < 60) begin
      @(posedge Clk);
      #1;
      waitCnt++;
    end
    check("postrst latency", waitCnt, 32);
    check("postrst data", OutData, modelApply(pk(100, 0, 0), 0));
    for (int i = 0; i < 10; i++) run("postrst impulse", pk(0, 0, 0), 0, modelApply(pk(0, 0, 0), 0), 0);

    // randomized traffic against the reference model
    doReset();
    for (int t = 0; t < TAPS; t++) wrCoef(t, int'($urandom_range(0, 32767)) - 16384);
    for (int n = 0; n < 40; n++) begin
      logic [NW-1:0] d;
      bit b;
      d = pk(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      b = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 7) == 0) wrCoef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)) - 32768);
      run($sformatf("rand%0d", n), d, b, modelApply(d, b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gyro_fir_filter.md
GYRO_FIR_FILTER -- requirements
Module: gyro_fir_filter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters (name, default, meaning):
- CHANNELS, 3, number of independent sensor channels.
- TAPS, 10, FIR depth per channel.
- DATA_W, 10, signed sample width.
- COEF_W, 16, signed coefficient width in Q1.(COEF_W-1).
- COEF_INIT, TAPS*COEF_W packed, reset coefficient set (tap 0 in LSBs).
REQ-003 Ports (name, direction, width, meaning):
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- SampleValid, in, 1, SampleData is valid this cycle.
- SampleReady, out, 1, block can accept a sample.
- SampleData, in, CHANNELS*DATA_W, packed samples, channel 0 in LSBs.
- Bypass, in, 1, 1 = pass samples through unfiltered.
- CoefWe, in, 1, coefficient write strobe.
- CoefAddr, in, clog2(TAPS), tap index to write.
- CoefData, in, COEF_W, coefficient value.
- OutValid, out, 1, one-cycle pulse; OutData is new.
- OutData, out, CHANNELS*DATA_W, packed filtered results.
- CoefDropped, out, 1, sticky flag: a coefficient write was rejected.

Function
REQ-004 All samples, coefficients and results SHALL be two's-complement signed.
REQ-005 A sample SHALL be accepted only on a cycle with SampleValid=1 and SampleReady=1; SampleValid while SampleReady=0 SHALL be ignored, not queued.
REQ-006 FSM states: IDLE, SHIFT, MAC, OUT.
- IDLE: SampleReady=1. Accept with Bypass=0 -> SHIFT. Accept with Bypass=1 -> OUT.
- SHIFT: per-channel history shifts one position; the new sample enters tap 0 and the oldest is discarded; -> MAC.
- MAC: exactly CHANNELS*TAPS cycles, one multiply-accumulate per cycle, channel-major, tap 0 first; -> OUT.
- OUT: OutValid=1 for this single cycle; -> IDLE.
REQ-007 SampleReady SHALL be 1 only in IDLE.
REQ-008 Filtered latency from acceptance edge to the OutValid cycle SHALL be CHANNELS*TAPS+2 cycles (32 at defaults). Bypass latency SHALL be 1 cycle.
REQ-009 The accumulator SHALL be DATA_W+COEF_W+clog2(TAPS) bits, cleared at the start of each channel, and SHALL never overflow.
REQ-010 Result per channel SHALL be computed as follows:
- Compute (acc + 2^(COEF_W-2)) arithmetic-shifted right by COEF_W-1 (round half up).
- Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 OutData SHALL hold its value between OutValid pulses.
REQ-012 In bypass, OutData SHALL equal SampleData and the history SHALL NOT shift.
REQ-013 Bypass SHALL be sampled only at acceptance; changes during SHIFT or MAC SHALL NOT affect the operation in progress.
REQ-014 CoefWe in IDLE with no simultaneous acceptance SHALL write CoefData to tap CoefAddr, effective for the next accepted sample.
REQ-015 CoefWe in any other cycle (busy, or coincident with acceptance) SHALL be dropped and SHALL set CoefDropped=1.
REQ-016 CoefAddr >= TAPS SHALL be dropped and SHALL set CoefDropped=1.
REQ-017 Coefficients SHALL be shared by all channels.

Reset
REQ-018 Reset_n=0 SHALL asynchronously force the following, at any point including mid-MAC, with no partial output ever emitted:
- FSM=IDLE, SampleReady=1 after release.
- OutValid=0, OutData=0, CoefDropped=0.
- All history registers=0, accumulator=0.
- Coefficients=COEF_INIT.
REQ-019 The first rising Clk edge after Reset_n deasserts SHALL be able to accept a sample.

Verification
REQ-020 Impulse: all coefficients 0x4000; channel 0 fed 100, then zeros; channels 1-2 held 0 -> channel 0 outputs 50 for 10 consecutive results, then 0; channels 1-2 stay 0.
REQ-021 Rounding: tap 0 = 0x4000, other taps 0; feed 1 -> 1; feed -1 -> 0; feed 3 -> 2.
REQ-022 Saturation: all coefficients 0x7FFF; repeated 511 -> second result onward 511; repeated -512 -> -512.
REQ-023 Handshake/latency: SampleValid held high continuously -> acceptances exactly 33 cycles apart; OutValid 32 cycles after each acceptance; Bypass=1 -> OutData=SampleData 1 cycle later.
REQ-024 Coefficient rules: CoefWe during MAC, or with CoefAddr=12 -> coefficient set unchanged and CoefDropped=1 until reset.
REQ-025 Reset mid-MAC: Reset_n low in MAC cycle 15 -> no OutValid; OutData=0; next impulse response matches COEF_INIT.
